boot_loader: RTL



---
 rtl/boot_loader.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed UART program, writes it into instruction memory and releases the core.
// Optional feature macro BOOT_CHECKSUM_EN: a trailing XOR checksum byte must follow the payload.
module boot_loader #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MAX_WORDS = 16384,
    parameter logic [7:0]  ACK_BYTE  = 8'hAA,
    parameter logic [7:0]  NAK_BYTE  = 8'h55
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rdata,
    input  logic              rdata_ready,
    input  logic              ferr,
    input  logic              tx_busy,
    output logic [7:0]        sdata,
    output logic              tx_start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    output logic              load_done,
    output logic              load_err,
    output logic [31:0]       word_count,
    output logic [7:0]        ferr_count
);

    typedef enum logic [2:0] {HDR, LOAD, ACK, ACKWAIT, RUN, ERR} state_t;

    localparam logic [31:0]       MAX_N    = 32'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        bytePos_q, bytePos_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W:0]   wrCount_q, wrCount_d;
    logic              nakDone_q, nakDone_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              chkPhase_q, chkPhase_d;
`endif

    logic [7:0]        sdata_q, sdata_d;
    logic              txStart_q, txStart_d;
    logic              imemWe_q, imemWe_d;
    logic [ADDR_W-1:0] imemAddr_q, imemAddr_d;
    logic [31:0]       imemWdata_q, imemWdata_d;
    logic              coreRstn_q, coreRstn_d;
    logic              loadDone_q, loadDone_d;
    logic              loadErr_q, loadErr_d;
    logic [31:0]       wordCount_q, wordCount_d;
    logic [7:0]        ferrCount_q, ferrCount_d;

    logic              goodByte;
    logic              badByte;
    logic [31:0]       hdrNext;
    logic [31:0]       asmNext;
    logic              lastWord;

    assign goodByte = rdata_ready && !ferr;
    assign badByte  = rdata_ready && ferr;
    assign hdrNext  = {wordCount_q[23:0], rdata};
    assign asmNext  = {asm_q, rdata};
    assign lastWord = ((32'(wrCount_q) + 32'd1) == wordCount_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HDR;
            bytePos_q   <= 2'd0;
            asm_q       <= '0;
            wrCount_q   <= '0;
            nakDone_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= 8'h00;
            chkPhase_q  <= 1'b0;
`endif
            sdata_q     <= 8'h00;
            txStart_q   <= 1'b0;
            imemWe_q    <= 1'b0;
            imemAddr_q  <= '0;
            imemWdata_q <= 32'h0;
            coreRstn_q  <= 1'b0;
            loadDone_q  <= 1'b0;
            loadErr_q   <= 1'b0;
            wordCount_q <= 32'h0;
            ferrCount_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            bytePos_q   <= bytePos_d;
            asm_q       <= asm_d;
            wrCount_q   <= wrCount_d;
            nakDone_q   <= nakDone_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
            chkPhase_q  <= chkPhase_d;
`endif
            sdata_q     <= sdata_d;
            txStart_q   <= txStart_d;
            imemWe_q    <= imemWe_d;
            imemAddr_q  <= imemAddr_d;
            imemWdata_q <= imemWdata_d;
            coreRstn_q  <= coreRstn_d;
            loadDone_q  <= loadDone_d;
            loadErr_q   <= loadErr_d;
            wordCount_q <= wordCount_d;
            ferrCount_q <= ferrCount_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bytePos_d   = bytePos_q;
        asm_d       = asm_q;
        wrCount_d   = wrCount_q;
        nakDone_d   = nakDone_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
        chkPhase_d  = chkPhase_q;
`endif
        sdata_d     = sdata_q;
        txStart_d   = 1'b0;
        imemWe_d    = 1'b0;
        // The address shows the written word during the strobe and moves on afterwards.
        imemAddr_d  = imemWe_q ? (imemAddr_q + ADDR_ONE) : imemAddr_q;
        imemWdata_d = imemWdata_q;
        coreRstn_d  = coreRstn_q;
        loadDone_d  = loadDone_q;
        loadErr_d   = loadErr_q;
        wordCount_d = wordCount_q;
        ferrCount_d = ferrCount_q;

        if ((state_q == HDR || state_q == LOAD) && badByte && ferrCount_q != 8'hFF) begin
            ferrCount_d = ferrCount_q + 8'd1;
        end

        case (state_q)
            HDR: begin
                if (goodByte) begin
                    wordCount_d = hdrNext;
                    bytePos_d   = bytePos_q + 2'd1;
                    if (bytePos_q == 2'd3) begin
                        if (hdrNext == 32'h0) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d    = LOAD;
                            chkPhase_d = 1'b1;
`else
                            state_d    = ACK;
`endif
                        end else if (hdrNext > MAX_N) begin
                            state_d   = ERR;
                            loadErr_d = 1'b1;
                        end else begin
                            state_d    = LOAD;
                            imemAddr_d = '0;
                            wrCount_d  = '0;
                        end
                    end
                end
            end

            LOAD: begin
`ifdef BOOT_CHECKSUM_EN
                if (goodByte && chkPhase_q) begin
                    chkPhase_d = 1'b0;
                    if (rdata == csum_q) begin
                        state_d = ACK;
                    end else begin
                        state_d   = ERR;
                        loadErr_d = 1'b1;
                    end
                end else
`endif
                if (goodByte) begin
                    asm_d     = asmNext[23:0];
                    bytePos_d = bytePos_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    csum_d    = csum_q ^ rdata;
`endif
                    if (bytePos_q == 2'd3) begin
                        imemWe_d    = 1'b1;
                        imemWdata_d = asmNext;
                        wrCount_d   = wrCount_q + CNT_ONE;
                        if (lastWord) begin
`ifdef BOOT_CHECKSUM_EN
                            chkPhase_d = 1'b1;
`else
                            state_d    = ACK;
`endif
                        end
                    end
                end
            end

            ACK: begin
                if (!tx_busy) begin
                    sdata_d   = loadErr_q ? NAK_BYTE : ACK_BYTE;
                    txStart_d = 1'b1;
                    state_d   = ACKWAIT;
                end
            end

            // The transmitter only raises busy after seeing the start pulse, so skip that cycle.
            ACKWAIT: begin
                if (!txStart_q && !tx_busy) begin
                    if (loadErr_q) begin
                        state_d   = ERR;
                        nakDone_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        coreRstn_d = 1'b1;
                        loadDone_d = 1'b1;
                    end
                end
            end

            RUN: begin
                state_d = RUN;
            end

            ERR: begin
                if (!nakDone_q) begin
                    state_d = ACK;
                end
            end

            default: begin
                state_d = HDR;
            end
        endcase
    end

    assign sdata      = sdata_q;
    assign tx_start   = txStart_q;
    assign imem_we    = imemWe_q;
    assign imem_addr  = imemAddr_q;
    assign imem_wdata = imemWdata_q;
    assign core_rstn  = coreRstn_q;
    assign load_done  = loadDone_q;
    assign load_err   = loadErr_q;
    assign word_count = wordCount_q;
    assign ferr_count = ferrCount_q;

endmodule
